// File: rtl/unidad_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// opcode field bounds and default widths/reset address.
package unidad_fetch_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 26;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_FETCH = 2'd1;
    localparam logic [1:0] STATE_STALL = 2'd2;
    localparam logic [1:0] STATE_ERROR = 2'd3;

endpackage

// File: rtl/unidad_fetch_if.sv
// Bundle of the fetch stage's memory-side handshake and IF/ID-side signals.
// master = fetch stage, slave = memory/decode environment.
interface unidad_fetch_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) ();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;

    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [5:0]         id_opcode;
    logic [PC_W-1:0]    id_pc_plus4;
    logic               fetch_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        input  stall, branch_taken, branch_target,
        output id_valid, id_instr, id_opcode, id_pc_plus4, fetch_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        output stall, branch_taken, branch_target,
        input  id_valid, id_instr, id_opcode, id_pc_plus4, fetch_err
    );

endinterface

// File: rtl/unidad_fetch_registro_pc.sv
// Program counter register with load (redirect), increment-by-4 and hold.
// Arithmetic is modulo 2^PC_W; the wrap from the top word to 0 is silent.
module registro_pc #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] loadVal,
    input  logic            inc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pcPlus4
);

    assign pcPlus4 = pc + PC_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= loadVal;
        end else if (inc) begin
            pc <= pcPlus4;
        end
    end

endmodule

// File: rtl/unidad_fetch.sv
// Instruction-fetch stage: FSM, PC and IF/ID register feeding the control unit.
// Optional misaligned-redirect trap enabled by UNIDAD_FETCH_ALIGN_CHK_EN.
module unidad_fetch
    import unidad_fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    unidad_fetch_if.master bus
);

    logic [1:0]         state;
    logic [1:0]         stateNext;
    logic               pcLoad;
    logic               pcInc;
    logic               idLoad;
    logic               idClear;
    logic               alignErr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pcPlus4;

    logic               idValid_p1;
    logic [INSTR_W-1:0] idInstr_p1;
    logic [PC_W-1:0]    idPcPlus4_p1;

`ifdef UNIDAD_FETCH_ALIGN_CHK_EN
    assign alignErr      = (bus.branch_target[1:0] != 2'b00);
    assign bus.fetch_err = (state == STATE_ERROR);
`else
    assign alignErr      = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    registro_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) uRegistroPc (
        .clk     (clk),
        .rst     (rst),
        .load    (pcLoad),
        .loadVal (bus.branch_target),
        .inc     (pcInc),
        .pc      (pc),
        .pcPlus4 (pcPlus4)
    );

    // Redirect beats stall; stall freezes PC and IF/ID so an overlapping
    // memory response is simply refetched once the stall clears.
    always_comb begin
        stateNext = state;
        pcLoad    = 1'b0;
        pcInc     = 1'b0;
        idLoad    = 1'b0;
        idClear   = 1'b0;
        if (state != STATE_ERROR) begin
            if (bus.branch_taken) begin
                idClear = 1'b1;
                if (alignErr) begin
                    stateNext = STATE_ERROR;
                end else begin
                    pcLoad    = 1'b1;
                    stateNext = STATE_FETCH;
                end
            end else if (bus.stall && idValid_p1) begin
                stateNext = STATE_STALL;
            end else begin
                case (state)
                    STATE_IDLE:  stateNext = STATE_FETCH;
                    STATE_STALL: stateNext = STATE_FETCH;
                    STATE_FETCH: begin
                        if (bus.imem_ready) begin
                            idLoad = 1'b1;
                            pcInc  = 1'b1;
                        end else begin
                            idClear = 1'b1;
                        end
                    end
                    default: stateNext = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // IF/ID stage boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            idValid_p1   <= 1'b0;
            idInstr_p1   <= '0;
            idPcPlus4_p1 <= '0;
        end else if (idClear) begin
            idValid_p1 <= 1'b0;
        end else if (idLoad) begin
            idValid_p1   <= 1'b1;
            idInstr_p1   <= bus.imem_rdata;
            idPcPlus4_p1 <= pcPlus4;
        end
    end

    assign bus.imem_req    = (state == STATE_FETCH);
    assign bus.imem_addr   = pc;
    assign bus.id_valid    = idValid_p1;
    assign bus.id_instr    = idInstr_p1;
    assign bus.id_opcode   = idInstr_p1[OPCODE_HI:OPCODE_LO];
    assign bus.id_pc_plus4 = idPcPlus4_p1;

endmodule

// File: tb/tb_unidad_fetch.sv
// Directed bench for unidad_fetch; expectations follow the macro
// UNIDAD_FETCH_ALIGN_CHK_EN when it is defined for the build.
module tb_unidad_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    unidad_fetch_if #(.PC_W(32), .INSTR_W(32)) ifc ();

    unidad_fetch #(
        .PC_W     (32),
        .INSTR_W  (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        ifc.imem_ready    = 1'b0;
        ifc.imem_rdata    = '0;
        ifc.stall         = 1'b0;
        ifc.branch_taken  = 1'b0;
        ifc.branch_target = '0;

        // Reset state
        tick(); tick();
        chk("rst_req", 32'(ifc.imem_req), 32'd0);
        chk("rst_valid", 32'(ifc.id_valid), 32'd0);
        chk("rst_instr", ifc.id_instr, 32'd0);
        chk("rst_pcp4", ifc.id_pc_plus4, 32'd0);
        chk("rst_addr", ifc.imem_addr, 32'd0);
        chk("rst_err", 32'(ifc.fetch_err), 32'd0);

        // IDLE cycle, then first request at PC 0
        rst = 1'b0;
        ifc.imem_ready = 1'b1;
        ifc.imem_rdata = 32'h0000_0020;
        chk("idle_req", 32'(ifc.imem_req), 32'd0);
        tick();
        chk("first_req", 32'(ifc.imem_req), 32'd1);
        chk("first_addr", ifc.imem_addr, 32'd0);
        chk("first_valid", 32'(ifc.id_valid), 32'd0);

        tick();
        chk("f0_valid", 32'(ifc.id_valid), 32'd1);
        chk("f0_instr", ifc.id_instr, 32'h0000_0020);
        chk("f0_opc", 32'(ifc.id_opcode), 32'h00);
        chk("f0_pcp4", ifc.id_pc_plus4, 32'd4);
        chk("f0_addr", ifc.imem_addr, 32'd4);

        ifc.imem_rdata = 32'h8C00_0004;
        tick();
        chk("f1_instr", ifc.id_instr, 32'h8C00_0004);
        chk("f1_opc", 32'(ifc.id_opcode), 32'h23);
        chk("f1_pcp4", ifc.id_pc_plus4, 32'd8);
        chk("f1_addr", ifc.imem_addr, 32'd8);

        // Memory not ready for three cycles
        ifc.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nrdy_addr", ifc.imem_addr, 32'd8);
            chk("nrdy_valid", 32'(ifc.id_valid), 32'd0);
            chk("nrdy_req", 32'(ifc.imem_req), 32'd1);
        end

        ifc.imem_ready = 1'b1;
        ifc.imem_rdata = 32'h1111_1111;
        tick();
        chk("f2_valid", 32'(ifc.id_valid), 32'd1);
        chk("f2_instr", ifc.id_instr, 32'h1111_1111);
        chk("f2_pcp4", ifc.id_pc_plus4, 32'h0000_000C);
        chk("f2_addr", ifc.imem_addr, 32'h0000_000C);

        // Stall for two cycles with a valid entry
        ifc.stall = 1'b1;
        ifc.imem_rdata = 32'h2222_2222;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stl_req", 32'(ifc.imem_req), 32'd0);
            chk("stl_addr", ifc.imem_addr, 32'h0000_000C);
            chk("stl_instr", ifc.id_instr, 32'h1111_1111);
            chk("stl_valid", 32'(ifc.id_valid), 32'd1);
            chk("stl_pcp4", ifc.id_pc_plus4, 32'h0000_000C);
        end
        ifc.stall = 1'b0;
        tick();
        chk("resume_req", 32'(ifc.imem_req), 32'd1);
        chk("resume_addr", ifc.imem_addr, 32'h0000_000C);
        chk("resume_instr", ifc.id_instr, 32'h1111_1111);
        tick();
        chk("f3_instr", ifc.id_instr, 32'h2222_2222);
        chk("f3_pcp4", ifc.id_pc_plus4, 32'h0000_0010);
        chk("f3_addr", ifc.imem_addr, 32'h0000_0010);

        // Branch with simultaneous stall and ready: branch wins, response dropped
        ifc.stall = 1'b1;
        ifc.branch_taken = 1'b1;
        ifc.branch_target = 32'h0000_0040;
        ifc.imem_rdata = 32'h3333_3333;
        tick();
        chk("br_addr", ifc.imem_addr, 32'h0000_0040);
        chk("br_valid", 32'(ifc.id_valid), 32'd0);
        chk("br_req", 32'(ifc.imem_req), 32'd1);
        chk("br_instr", ifc.id_instr, 32'h2222_2222);
        ifc.stall = 1'b0;

        // Redirect to the top word, then wrap
        ifc.branch_target = 32'hFFFF_FFFC;
        tick();
        chk("top_addr", ifc.imem_addr, 32'hFFFF_FFFC);
        chk("top_valid", 32'(ifc.id_valid), 32'd0);
        ifc.branch_taken = 1'b0;
        ifc.imem_rdata = 32'h4444_4444;
        tick();
        chk("wrap_addr", ifc.imem_addr, 32'd0);
        chk("wrap_pcp4", ifc.id_pc_plus4, 32'd0);
        chk("wrap_valid", 32'(ifc.id_valid), 32'd1);
        chk("wrap_instr", ifc.id_instr, 32'h4444_4444);
        ifc.imem_rdata = 32'h5555_5555;
        tick();
        chk("thru_addr", ifc.imem_addr, 32'd4);
        chk("thru_pcp4", ifc.id_pc_plus4, 32'd4);
        chk("thru_instr", ifc.id_instr, 32'h5555_5555);

        // Misaligned redirect
        ifc.branch_taken = 1'b1;
        ifc.branch_target = 32'h0000_0042;
        tick();
        ifc.branch_taken = 1'b0;
`ifdef UNIDAD_FETCH_ALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            chk("err_flag", 32'(ifc.fetch_err), 32'd1);
            chk("err_req", 32'(ifc.imem_req), 32'd0);
            chk("err_valid", 32'(ifc.id_valid), 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("err_clr", 32'(ifc.fetch_err), 32'd0);
        chk("err_rst_addr", ifc.imem_addr, 32'd0);
        rst = 1'b0;
        tick();
        tick();
`else
        chk("mis_addr", ifc.imem_addr, 32'h0000_0042);
        chk("mis_req", 32'(ifc.imem_req), 32'd1);
        chk("mis_err", 32'(ifc.fetch_err), 32'd0);
        chk("mis_valid", 32'(ifc.id_valid), 32'd0);
`endif

        // Reset during an in-flight handshake discards the response
        chk("pre_rst_req", 32'(ifc.imem_req), 32'd1);
        ifc.imem_ready = 1'b1;
        ifc.imem_rdata = 32'h6666_6666;
        rst = 1'b1;
        tick();
        chk("rstf_valid", 32'(ifc.id_valid), 32'd0);
        chk("rstf_instr", ifc.id_instr, 32'd0);
        chk("rstf_addr", ifc.imem_addr, 32'd0);
        chk("rstf_req", 32'(ifc.imem_req), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_req", 32'(ifc.imem_req), 32'd1);
        chk("post_rst_addr", ifc.imem_addr, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
